// File: rtl/id_ex_pkg.sv
// Shared decode constants, multiply/divide FSM states and helpers for the ID/EX execute stage.
package id_ex_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnMfhi = 6'h10;
  localparam logic [5:0] FnMflo = 6'h12;
  localparam logic [5:0] FnMult = 6'h18;
  localparam logic [5:0] FnDiv  = 6'h1A;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;

  localparam int unsigned IterCount = 32;

  typedef enum logic [1:0] {MdIdle, MdBusy, MdDone} md_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/read_id_ex_if.sv
// ID_EX slot inputs and EX_MEM result outputs of the execute stage.
interface read_id_ex_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        controller_EX;
  logic [5:0]        opcode_ex;
  logic [5:0]        func_ex;
  logic [4:0]        shamt_ex;
  logic [DATA_W-1:0] exec_data_1;
  logic [DATA_W-1:0] exec_data_2;
  logic [4:0]        exec_rd;
  logic [15:0]       immediate_ex;
  logic [25:0]       address_ex;

  logic              stall_ex;
  logic              mem_valid;
  logic [DATA_W-1:0] alu_result_mem;
  logic [DATA_W-1:0] store_data_mem;
  logic [4:0]        rd_mem;
  logic [7:0]        controller_MEM;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;

  modport master (
    output in_valid, controller_EX, opcode_ex, func_ex, shamt_ex, exec_data_1, exec_data_2,
           exec_rd, immediate_ex, address_ex,
    input  stall_ex, mem_valid, alu_result_mem, store_data_mem, rd_mem, controller_MEM,
           branch_taken, branch_target
  );

  modport slave (
    input  in_valid, controller_EX, opcode_ex, func_ex, shamt_ex, exec_data_1, exec_data_2,
           exec_rd, immediate_ex, address_ex,
    output stall_ex, mem_valid, alu_result_mem, store_data_mem, rd_mem, controller_MEM,
           branch_taken, branch_target
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative signed multiply/divide (one step per cycle) owning the HI/LO registers.
module muldiv_iter
  import id_ex_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mag_q, mag_d;
  logic [31:0] dividend_q, dividend_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [63:0] prod;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    mag_d      = mag_q;
    dividend_d = dividend_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    // Operands are held as magnitudes; signs are reapplied once in the done state.
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
    trial   = {acc_q[63:32], acc_q[31]} - {1'b0, mag_q};
    prod    = neg_lo_q ? (~acc_q + 64'd1) : acc_q;

    unique case (state_q)
      MdIdle: begin
        if (start) begin
          state_d    = MdBusy;
          count_d    = '0;
          is_div_d   = is_div;
          mag_d      = is_div ? mag32(op_b) : mag32(op_a);
          acc_d      = {32'd0, is_div ? mag32(op_a) : mag32(op_b)};
          neg_lo_d   = op_a[31] ^ op_b[31];
          neg_hi_d   = is_div ? op_a[31] : (op_a[31] ^ op_b[31]);
          div0_d     = (op_b == 32'd0);
          dividend_d = op_a;
        end
      end
      MdBusy: begin
        count_d = count_q + 6'd1;
        if (!is_div_q) begin
          acc_d = {add_sum, acc_q[31:1]};
        end else if (!trial[32]) begin
          acc_d = {trial[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {acc_q[62:0], 1'b0};
        end
        if (count_q == 6'(IterCount - 1)) state_d = MdDone;
      end
      MdDone: begin
        state_d = MdIdle;
        if (!is_div_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (div0_q) begin
          hi_d = dividend_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
          lo_d = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= MdIdle;
      count_q    <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      mag_q      <= mag_d;
      dividend_q <= dividend_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q != MdIdle);
  assign done = (state_q == MdDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/read_id_ex.sv
// Execute stage: decodes the ID_EX slot and registers the EX_MEM result.
// Define MULDIV_EN to add mult/div/mfhi/mflo with HI/LO and the iterative unit.
module read_id_ex
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic         clock,
  input logic         reset,
  read_id_ex_if.slave bus
);

  logic              accept;
  logic              recog;
  logic              md_start;
  logic              md_is_div;
  logic              md_busy;
  logic              md_done;
  logic [DATA_W-1:0] rs, rt, sext_imm, zext_imm;
  logic [DATA_W-1:0] res_c, st_c, tg_c;
  logic              tk_c;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [4:0]        rd_q, rd_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;

`ifdef MULDIV_EN
  logic [DATA_W-1:0] md_hi, md_lo;

  muldiv_iter u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div),
    .op_a   (rs),
    .op_b   (rt),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );
`else
  assign md_busy = 1'b0;
  assign md_done = 1'b0;
`endif

  assign rs       = bus.exec_data_1;
  assign rt       = bus.exec_data_2;
  assign sext_imm = {{(DATA_W-16){bus.immediate_ex[15]}}, bus.immediate_ex};
  assign zext_imm = {{(DATA_W-16){1'b0}}, bus.immediate_ex};
  assign accept   = bus.in_valid && !md_busy;

  always_comb begin
    recog     = 1'b1;
    res_c     = '0;
    st_c      = '0;
    tk_c      = 1'b0;
    tg_c      = '0;
    md_start  = 1'b0;
    md_is_div = 1'b0;

    unique case (bus.opcode_ex)
      OpRtype: begin
        unique case (bus.func_ex)
          FnAdd:  res_c = rs + rt;
          FnSub:  res_c = rs - rt;
          FnAnd:  res_c = rs & rt;
          FnOr:   res_c = rs | rt;
          FnSlt:  res_c = {{(DATA_W-1){1'b0}}, ($signed(rs) < $signed(rt))};
          FnSll:  res_c = rt << bus.shamt_ex;
          FnSrl:  res_c = rt >> bus.shamt_ex;
`ifdef MULDIV_EN
          // mult/div complete later from the iterative unit, not this cycle.
          FnMult, FnDiv: begin
            recog     = 1'b0;
            md_start  = accept;
            md_is_div = (bus.func_ex == FnDiv);
          end
          FnMfhi: res_c = md_hi;
          FnMflo: res_c = md_lo;
`endif
          default: recog = 1'b0;
        endcase
      end
      OpAddi: res_c = rs + sext_imm;
      OpAndi: res_c = rs & zext_imm;
      OpOri:  res_c = rs | zext_imm;
      OpLw, OpSw: begin
        res_c = rs + sext_imm;
        st_c  = rt;
      end
      OpBeq: begin
        tk_c = (rs == rt);
        tg_c = sext_imm;
      end
      OpJ: begin
        tk_c = 1'b1;
        tg_c = {{(DATA_W-26){1'b0}}, bus.address_ex};
      end
      default: recog = 1'b0;
    endcase
  end

  always_comb begin
    valid_d  = 1'b0;
    result_d = '0;
    store_d  = '0;
    rd_d     = '0;
    ctrl_d   = '0;
    taken_d  = 1'b0;
    target_d = '0;
    if (md_done) begin
      valid_d = 1'b1;
    end else if (accept && recog) begin
      valid_d  = 1'b1;
      result_d = res_c;
      store_d  = st_c;
      rd_d     = bus.exec_rd;
      ctrl_d   = bus.controller_EX;
      taken_d  = tk_c;
      target_d = tg_c;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.stall_ex       = md_busy;
  assign bus.mem_valid      = valid_q;
  assign bus.alu_result_mem = result_q;
  assign bus.store_data_mem = store_q;
  assign bus.rd_mem         = rd_q;
  assign bus.controller_MEM = ctrl_q;
  assign bus.branch_taken   = taken_q;
  assign bus.branch_target  = target_q;

endmodule

// File: tb/tb_read_id_ex.sv
// Scoreboard bench for read_id_ex: issued instructions push expected EX_MEM results,
// a negedge monitor pops and compares whenever mem_valid is high.
module tb_read_id_ex;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  read_id_ex_if #(.DATA_W(32)) bus ();

  read_id_ex #(.DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic        tk;
    logic [31:0] tg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, got, want);
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic [31:0] st, input logic [4:0] rd,
                              input logic [7:0] ctrl, input logic tk, input logic [31:0] tg);
    exp_t e;
    e.res = res; e.st = st; e.rd = rd; e.ctrl = ctrl; e.tk = tk; e.tg = tg;
    return e;
  endfunction

  task automatic drive_idle();
    bus.in_valid      = 1'b0;
    bus.controller_EX = '0;
    bus.opcode_ex     = '0;
    bus.func_ex       = '0;
    bus.shamt_ex      = '0;
    bus.exec_data_1   = '0;
    bus.exec_data_2   = '0;
    bus.exec_rd       = '0;
    bus.immediate_ex  = '0;
    bus.address_ex    = '0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [25:0] addr, input logic [7:0] ctrl,
                       input bit push, input exp_t e);
    int waited = 0;
    while (bus.stall_ex === 1'b1 && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
    if (waited >= 200) begin
      n_checks++;
      $display("FAIL issue_wait: stall_ex still %b after %0d cycles, required 0",
               bus.stall_ex, waited);
    end
    bus.opcode_ex     = op;
    bus.func_ex       = fn;
    bus.shamt_ex      = sh;
    bus.exec_data_1   = a;
    bus.exec_data_2   = b;
    bus.exec_rd       = rd;
    bus.immediate_ex  = imm;
    bus.address_ex    = addr;
    bus.controller_EX = ctrl;
    bus.in_valid      = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall_ex"}, {31'd0, bus.stall_ex}, 32'd0);
    check({tag, "_mem_valid"}, {31'd0, bus.mem_valid}, 32'd0);
    check({tag, "_alu_result_mem"}, bus.alu_result_mem, 32'd0);
    check({tag, "_store_data_mem"}, bus.store_data_mem, 32'd0);
    check({tag, "_rd_mem"}, {27'd0, bus.rd_mem}, 32'd0);
    check({tag, "_controller_MEM"}, {24'd0, bus.controller_MEM}, 32'd0);
    check({tag, "_branch_taken"}, {31'd0, bus.branch_taken}, 32'd0);
    check({tag, "_branch_target"}, bus.branch_target, 32'd0);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && bus.mem_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: mem_valid 1 with result %h, required no output",
                 bus.alu_result_mem);
      end else begin
        mon_e = exp_q.pop_front();
        check("alu_result_mem", bus.alu_result_mem, mon_e.res);
        check("store_data_mem", bus.store_data_mem, mon_e.st);
        check("rd_mem", {27'd0, bus.rd_mem}, {27'd0, mon_e.rd});
        check("controller_MEM", {24'd0, bus.controller_MEM}, {24'd0, mon_e.ctrl});
        check("branch_taken", {31'd0, bus.branch_taken}, {31'd0, mon_e.tk});
        check("branch_target", bus.branch_target, mon_e.tg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive_idle();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;

    issue(6'h00, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1, 5'd5, 16'h0, 26'h0, 8'hA5, 1,
          mk(32'h8000_0000, 32'h0, 5'd5, 8'hA5, 1'b0, 32'h0));
    issue(6'h00, 6'h22, 5'd0, 32'd5, 32'd7, 5'd3, 16'h0, 26'h0, 8'h01, 1,
          mk(32'hFFFF_FFFE, 32'h0, 5'd3, 8'h01, 1'b0, 32'h0));
    issue(6'h00, 6'h24, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd4, 16'h0, 26'h0, 8'h02, 1,
          mk(32'h00F0_1200, 32'h0, 5'd4, 8'h02, 1'b0, 32'h0));
    issue(6'h00, 6'h25, 5'd0, 32'hF000_0000, 32'h0000_000F, 5'd6, 16'h0, 26'h0, 8'h03, 1,
          mk(32'hF000_000F, 32'h0, 5'd6, 8'h03, 1'b0, 32'h0));
    issue(6'h00, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd7, 16'h0, 26'h0, 8'h04, 1,
          mk(32'h1, 32'h0, 5'd7, 8'h04, 1'b0, 32'h0));
    issue(6'h00, 6'h2A, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd7, 16'h0, 26'h0, 8'h04, 1,
          mk(32'h0, 32'h0, 5'd7, 8'h04, 1'b0, 32'h0));
    issue(6'h00, 6'h00, 5'd31, 32'h0, 32'h1, 5'd8, 16'h0, 26'h0, 8'h05, 1,
          mk(32'h8000_0000, 32'h0, 5'd8, 8'h05, 1'b0, 32'h0));
    issue(6'h00, 6'h02, 5'd4, 32'h0, 32'h8000_0000, 5'd9, 16'h0, 26'h0, 8'h06, 1,
          mk(32'h0800_0000, 32'h0, 5'd9, 8'h06, 1'b0, 32'h0));
    issue(6'h08, 6'h00, 5'd0, 32'h0, 32'h0, 5'd10, 16'h8000, 26'h0, 8'h07, 1,
          mk(32'hFFFF_8000, 32'h0, 5'd10, 8'h07, 1'b0, 32'h0));
    issue(6'h0C, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd11, 16'h8001, 26'h0, 8'h08, 1,
          mk(32'h0000_8001, 32'h0, 5'd11, 8'h08, 1'b0, 32'h0));
    issue(6'h0D, 6'h00, 5'd0, 32'h1234_0000, 32'h0, 5'd12, 16'h8000, 26'h0, 8'h09, 1,
          mk(32'h1234_8000, 32'h0, 5'd12, 8'h09, 1'b0, 32'h0));
    issue(6'h23, 6'h00, 5'd0, 32'h100, 32'hDEAD, 5'd13, 16'hFFFC, 26'h0, 8'h0A, 1,
          mk(32'h0000_00FC, 32'hDEAD, 5'd13, 8'h0A, 1'b0, 32'h0));
    issue(6'h2B, 6'h00, 5'd0, 32'h1000, 32'hCAFE_BABE, 5'd14, 16'h0004, 26'h0, 8'h0B, 1,
          mk(32'h0000_1004, 32'hCAFE_BABE, 5'd14, 8'h0B, 1'b0, 32'h0));
    issue(6'h04, 6'h00, 5'd0, 32'h55, 32'h55, 5'd15, 16'hFFFE, 26'h0, 8'h0C, 1,
          mk(32'h0, 32'h0, 5'd15, 8'h0C, 1'b1, 32'hFFFF_FFFE));
    issue(6'h04, 6'h00, 5'd0, 32'h55, 32'h56, 5'd15, 16'h0010, 26'h0, 8'h0C, 1,
          mk(32'h0, 32'h0, 5'd15, 8'h0C, 1'b0, 32'h0000_0010));
    issue(6'h02, 6'h00, 5'd0, 32'h0, 32'h0, 5'd16, 16'h0, 26'h000_0010, 8'h0D, 1,
          mk(32'h0, 32'h0, 5'd16, 8'h0D, 1'b1, 32'h0000_0010));

    // Unrecognised opcode and R-type func: bubble, nothing pushed.
    issue(6'h3F, 6'h00, 5'd0, 32'h1, 32'h2, 5'd17, 16'h1, 26'h1, 8'hFF, 0, '0);
    check("bubble_op_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("bubble_op_controller_MEM", {24'd0, bus.controller_MEM}, 32'd0);
    issue(6'h00, 6'h3F, 5'd0, 32'h1, 32'h2, 5'd18, 16'h0, 26'h0, 8'hFF, 0, '0);
    check("bubble_fn_alu_result_mem", bus.alu_result_mem, 32'd0);

`ifdef MULDIV_EN
    issue(6'h00, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'd7, 5'd0, 16'h0, 26'h0, 8'h00, 1, '0);
    n = 0;
    while (bus.stall_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
    check("mult_stall_cycles", n, 32'd33);
    issue(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 5'd8, 16'h0, 26'h0, 8'h11, 1,
          mk(32'hFFFF_FFEB, 32'h0, 5'd8, 8'h11, 1'b0, 32'h0));
    issue(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 5'd9, 16'h0, 26'h0, 8'h12, 1,
          mk(32'hFFFF_FFFF, 32'h0, 5'd9, 8'h12, 1'b0, 32'h0));

    issue(6'h00, 6'h1A, 5'd0, 32'd9, 32'd0, 5'd0, 16'h0, 26'h0, 8'h00, 1, '0);
    issue(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 5'd1, 16'h0, 26'h0, 8'h13, 1,
          mk(32'hFFFF_FFFF, 32'h0, 5'd1, 8'h13, 1'b0, 32'h0));
    issue(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 5'd2, 16'h0, 26'h0, 8'h14, 1,
          mk(32'h0000_0009, 32'h0, 5'd2, 8'h14, 1'b0, 32'h0));

    issue(6'h00, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2, 5'd0, 16'h0, 26'h0, 8'h00, 1, '0);
    issue(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 5'd3, 16'h0, 26'h0, 8'h15, 1,
          mk(32'hFFFF_FFFD, 32'h0, 5'd3, 8'h15, 1'b0, 32'h0));
    issue(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 5'd4, 16'h0, 26'h0, 8'h16, 1,
          mk(32'hFFFF_FFFF, 32'h0, 5'd4, 8'h16, 1'b0, 32'h0));

    // Abort a mult at iteration 10; HI/LO must read back as cleared.
    issue(6'h00, 6'h18, 5'd0, 32'h1234_5678, 32'd3, 5'd0, 16'h0, 26'h0, 8'h00, 0, '0);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check_outputs_zero("abort");
    issue(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 5'd5, 16'h0, 26'h0, 8'h17, 1,
          mk(32'h0, 32'h0, 5'd5, 8'h17, 1'b0, 32'h0));
    issue(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 5'd6, 16'h0, 26'h0, 8'h18, 1,
          mk(32'h0, 32'h0, 5'd6, 8'h18, 1'b0, 32'h0));
`else
    // Without the multiply/divide unit these funcs are bubbles and never stall.
    issue(6'h00, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'd7, 5'd0, 16'h0, 26'h0, 8'h33, 0, '0);
    check("nomd_mult_stall_ex", {31'd0, bus.stall_ex}, 32'd0);
    check("nomd_mult_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    issue(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 5'd9, 16'h0, 26'h0, 8'h34, 0, '0);
    check("nomd_mfhi_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("nomd_mfhi_controller_MEM", {24'd0, bus.controller_MEM}, 32'd0);
`endif

    repeat (5) @(posedge clock);
    #1;
    check("queue_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/read_id_ex.md
READ_ID_EX -- requirements
Module: read_id_ex

Interface
REQ-001 SHALL have parameter: DATA_W, 32, datapath width; only 32 is supported.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have inputs: in_valid 1 (ID_EX slot holds a live instruction); controller_EX 8 (control bits); opcode_ex 6; func_ex 6; shamt_ex 5; exec_data_1 32 (rs); exec_data_2 32 (rt); exec_rd 5 (destination); immediate_ex 16; address_ex 26 (jump field).
REQ-005 SHALL have outputs: stall_ex 1 (upstream must hold ID_EX); mem_valid 1; alu_result_mem 32; store_data_mem 32; rd_mem 5; controller_MEM 8; branch_taken 1; branch_target 32 (word-index form).
REQ-006 SHALL state: reset is `reset`, synchronous, active-low; clock is `clock`.

Function
REQ-007 SHALL register all EX_MEM outputs, so a result appears one cycle after acceptance.
REQ-008 SHALL accept an instruction on a clock edge where in_valid=1 and stall_ex=0.
REQ-009 SHALL decode R-type (opcode 0) by func:
- 0x20 add, 0x22 sub: wrap modulo 2^32, no overflow trap.
- 0x24 and, 0x25 or.
- 0x2A slt: signed compare.
- 0x00 sll, 0x02 srl: shift rt by shamt_ex.
- 0x18 mult, 0x1A div: signed.
- 0x10 mfhi, 0x12 mflo.
REQ-010 SHALL decode I/J-type:
- 0x08 addi: sign-extended immediate.
- 0x0C andi, 0x0D ori: zero-extended immediate.
- 0x23 lw, 0x2B sw: result = rs + sign-extended immediate; store_data_mem = rt.
- 0x04 beq: branch_taken = (rs == rt); branch_target = sign-extended immediate.
- 0x02 j: branch_taken=1; branch_target = zero-extended address_ex.
REQ-011 SHALL forward exec_rd to rd_mem and controller_EX to controller_MEM for every valid, recognised instruction.
REQ-012 SHALL treat an unrecognised opcode/func as a bubble: mem_valid=0, controller_MEM=0, alu_result_mem=0.
REQ-013 SHALL drive mem_valid=0 and controller_MEM=0 on any cycle where no instruction completes.
REQ-014 SHALL run mult/div in a 3-state FSM:
- IDLE -> BUSY on accepting mult or div.
- BUSY: 32 iterations, one per cycle.
- BUSY -> DONE after the 32nd iteration.
- DONE -> IDLE after one cycle.
REQ-015 SHALL hold stall_ex=1 from the cycle after mult/div acceptance until the FSM returns to IDLE, making mult/div 34 cycles to the next acceptance.
REQ-016 SHALL ignore in_valid while stall_ex=1.
REQ-017 SHALL, in DONE: write HI/LO; mult gives HI:LO = 64-bit product; div gives LO = quotient, HI = remainder (remainder takes the sign of the dividend); set mem_valid=1 with controller_MEM=0 (no register write).
REQ-018 SHALL, on div by zero: set LO=0xFFFFFFFF and HI=dividend, with no other side effect.
REQ-019 SHALL return HI/LO as they stand after any prior completed mult/div for mfhi/mflo; no mfhi/mflo can be accepted while BUSY.

Reset
REQ-020 SHALL, while reset=0 at a clock edge, clear all outputs, HI, LO and iteration counters to 0 and force the FSM to IDLE.
REQ-021 SHALL abort an in-flight mult/div on reset, with no HI/LO update and stall_ex=0 on the next cycle.

Configuration
REQ-022 SHALL, with MULDIV_EN defined, implement REQ-014 to REQ-019 and REQ-021.
REQ-023 SHALL, without MULDIV_EN, treat func 0x18/0x1A/0x10/0x12 as unrecognised (REQ-012), tie stall_ex=0, and remove HI/LO and the FSM.

Structure
REQ-024 SHALL place opcode/func constants, the FSM state enum and the iteration-count constant (32) in shared package id_ex_pkg.
REQ-025 SHALL implement mult/div in sub-module muldiv_iter, instantiated only under MULDIV_EN.

Verification
REQ-026 SHALL cover: add, rs=0x7FFFFFFF, rt=1, rd=5 -> next cycle alu_result_mem=0x80000000, rd_mem=5, mem_valid=1.
REQ-027 SHALL cover: slt, rs=0xFFFFFFFF, rt=0 -> result 1; addi with imm 0x8000, rs=0 -> result 0xFFFF8000.
REQ-028 SHALL cover: beq, equal operands, imm=0xFFFE -> branch_taken=1, branch_target=0xFFFFFFFE; j, address 0x0000010 -> target 0x10.
REQ-029 SHALL cover: mult, rs=-3, rt=7 -> stall_ex high 33 cycles; then mflo returns 0xFFFFFFEB and mfhi returns 0xFFFFFFFF.
REQ-030 SHALL cover: div, rt=0, rs=9 -> LO=0xFFFFFFFF, HI=9; div -7/2 -> LO=-3, HI=-1.
REQ-031 SHALL cover: reset asserted at iteration 10 of mult -> next cycle stall_ex=0, all outputs 0, and mfhi after reset returns 0.
